mdu: RTL

Multiply/divide unit for the MIPS core: executes MULT, MULTU, DIV and DIVU iteratively and holds the architectural HI/LO registers. It sits in the execute stage directly downstream of the general purpose register file. It consumes the two register-file read ports as operands, and its HI/LO outputs feed the EX result mux for MFHI/MFLO, which write back into the register file. The pipeline stalls on `busy`.

---
 rtl/mdu_if.sv | 22 ++
 rtl/mdu.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mdu_if.sv
// mdu_if: operand/issue and result bundle between the execute stage and the
// multiply/divide unit.
//   start - issue strobe for op (master -> slave)
//   op    - 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved
//   rrs   - operand A (rs)
//   rrt   - operand B (rt)
//   busy  - long operation in flight (slave -> master)
//   done  - one-cycle pulse, HI/LO just written by a long operation
//   hi/lo - architectural HI/LO registers
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rrs;
  logic [31:0] rrt;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, rrs, rrt, input busy, done, hi, lo);
  modport slave  (input start, op, rrs, rrt, output busy, done, hi, lo);
endinterface

// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit holding HI/LO.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring division; both
// run on operand magnitudes for 32 cycles, then one FIX cycle applies signs
// and writes HI/LO. MTHI/MTLO write directly in one cycle.
//   clk - clock, rising edge
//   rst - asynchronous active-low reset
//   bus - mdu_if.slave (start/op/rrs/rrt in, busy/done/hi/lo out)
module mdu (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] opb_q, opb_d;     // multiplicand or divisor magnitude
  logic [63:0] acc_q, acc_d;     // mul: {partial, multiplier}; div: {rem, dividend/quotient}
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;  // product / quotient negative
  logic        neg_rem_q, neg_rem_d;  // remainder takes dividend sign
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        sgn;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_top;
  logic [31:0] div_rem;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    sgn     = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_neg   = sgn && bus.rrs[31];
    b_neg   = sgn && bus.rrt[31];
    a_mag   = a_neg ? (~bus.rrs + 32'd1) : bus.rrs;
    b_mag   = b_neg ? (~bus.rrt + 32'd1) : bus.rrt;

    mul_sum = {1'b0, acc_q[63:32]} + {1'b0, opb_q};
    // Partial remainder shifted left with the next dividend bit brought in.
    div_top = acc_q[63:31];
    // Modular subtract is exact whenever the trial succeeds; with a zero
    // divisor it degenerates to a plain shift, leaving the dividend in rem.
    div_rem = div_top[31:0] - opb_q;

    prod    = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    quo     = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem     = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MTHI: hi_d = bus.rrs;
            OP_MTLO: lo_d = bus.rrs;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              div0_d    = ((bus.op == OP_DIV) || (bus.op == OP_DIVU)) && (bus.rrt == '0);
              opb_d     = b_mag;
              acc_d     = {32'd0, a_mag};
              cnt_d     = 5'd31;
              state_d   = S_RUN;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          if (div_top >= {1'b0, opb_q}) acc_d = {div_rem, acc_q[30:0], 1'b1};
          else                          acc_d = {acc_q[62:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {mul_sum, acc_q[31:1]};
          else          acc_d = {1'b0, acc_q[63:1]};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = div0_q ? '1 : quo;
          hi_d = rem;
        end else begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
